// File: rtl/time_keeper_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : time_keeper_ctrl
//  Purpose  : Alarm-clock time/alarm registers, 1 Hz divider, edit and ring FSM.
//  Revision : 1.0
// ============================================================================
module time_keeper_ctrl #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       adjust,
    input  logic [4:0] en,
    input  logic       up,
    input  logic       down,
    input  logic       alarm_off,
    output logic [4:0] clk_hour,
    output logic [5:0] clk_min,
    output logic [5:0] clk_sec,
    output logic [4:0] alm_hour,
    output logic [5:0] alm_min,
    output logic       alarm_armed,
    output logic       alarm_ring,
    output logic       sec_tick
);

    localparam int             CW        = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  c_cnt_max = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_RING = 2'd1,
        S_ADJ  = 2'd2
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [4:0]    r_hour;
    logic [5:0]    r_min;
    logic [5:0]    r_sec;
    logic [4:0]    r_ahour;
    logic [5:0]    r_amin;
    logic          r_armed;
    logic          r_ring;
    logic          r_stick;

    logic          w_tick;
    logic          w_sec_wrap;
    logic          w_min_wrap;
    logic [5:0]    w_sec_nxt;
    logic [5:0]    w_min_nxt;
    logic [4:0]    w_hour_nxt;
    logic          w_advance;
    logic          w_match;
    logic          w_edit;

    // Wrapping +/-1 on a single field; edits never carry.
    function automatic logic [5:0] f_step6(input logic [5:0] v, input logic [5:0] vmax,
                                           input logic inc);
        if (inc)
            return (v == vmax) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? vmax : v - 6'd1;
    endfunction

    function automatic logic [4:0] f_step5(input logic [4:0] v, input logic [4:0] vmax,
                                           input logic inc);
        if (inc)
            return (v == vmax) ? 5'd0 : v + 5'd1;
        return (v == 5'd0) ? vmax : v - 5'd1;
    endfunction

    assign w_tick     = (r_cnt == c_cnt_max);
    assign w_sec_wrap = (r_sec == 6'd59);
    assign w_min_wrap = (r_min == 6'd59);
    assign w_sec_nxt  = w_sec_wrap ? 6'd0 : r_sec + 6'd1;
    assign w_min_nxt  = !w_sec_wrap ? r_min : (w_min_wrap ? 6'd0 : r_min + 6'd1);
    assign w_hour_nxt = !(w_sec_wrap && w_min_wrap) ? r_hour
                      : ((r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1);

    // A tick coinciding with a rising adjust is dropped so time freezes on that edge.
    assign w_advance  = w_tick && !adjust && (r_state != S_ADJ);
    assign w_match    = w_advance && (r_state == S_RUN) && r_armed && w_sec_wrap
                      && (w_hour_nxt == r_ahour) && (w_min_nxt == r_amin);
    assign w_edit     = (r_state == S_ADJ) && (up ^ down) && !en[4] && $onehot(en[3:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_hour  <= '0;
            r_min   <= '0;
            r_sec   <= '0;
            r_ahour <= '0;
            r_amin  <= '0;
            r_armed <= 1'b0;
            r_ring  <= 1'b0;
            r_stick <= 1'b0;
        end else begin
            r_cnt   <= w_tick ? '0 : r_cnt + CW'(1);
            r_stick <= w_tick;

            if (w_advance) begin
                r_sec  <= w_sec_nxt;
                r_min  <= w_min_nxt;
                r_hour <= w_hour_nxt;
            end

            if (w_edit) begin
                if (en[0]) begin
                    r_min <= f_step6(r_min, 6'd59, up);
                    r_sec <= 6'd0;
                end else if (en[1]) begin
                    r_hour <= f_step5(r_hour, 5'd23, up);
                    r_sec  <= 6'd0;
                end else if (en[2]) begin
                    r_amin  <= f_step6(r_amin, 6'd59, up);
                    r_armed <= 1'b1;
                end else begin
                    r_ahour <= f_step5(r_ahour, 5'd23, up);
                    r_armed <= 1'b1;
                end
            end

            if (adjust) begin
                r_state <= S_ADJ;
                r_ring  <= 1'b0;
            end else begin
                case (r_state)
                    S_RUN: begin
                        if (w_match && !alarm_off) begin
                            r_state <= S_RING;
                            r_ring  <= 1'b1;
                        end
                    end
                    S_RING: begin
                        // Ringing stops on silence or once the matched minute has passed.
                        if (alarm_off || (w_advance && w_sec_wrap)) begin
                            r_state <= S_RUN;
                            r_ring  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_RUN;
                        r_ring  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign clk_hour    = r_hour;
    assign clk_min     = r_min;
    assign clk_sec     = r_sec;
    assign alm_hour    = r_ahour;
    assign alm_min     = r_amin;
    assign alarm_armed = r_armed;
    assign alarm_ring  = r_ring;
    assign sec_tick    = r_stick;

endmodule
`default_nettype wire

// File: doc/time_keeper_ctrl.md
# time_keeper_ctrl

Timekeeping controller for the digital alarm clock. Owns the clock time registers (hours, minutes, seconds) and the alarm registers, and shares them between two sources: the free-running 1 Hz second tick and user edits steered by the mode FSM's `adjust` and one-hot `EN` outputs. It also detects the alarm match and sequences the ringing state until the user silences it. It sits between the button-debounce/FSM layer and the display multiplexer.

## Interface
- `TICK_DIV`, 100_000_000: clock cycles per second tick; must be ≥2. Benches use 4.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `adjust` in 1: level from mode FSM; 1 = edit mode.
- `en` in 5: one-hot field select from mode FSM:
  - [0] clock minutes
  - [1] clock hours
  - [2] alarm minutes
  - [3] alarm hours
  - [4] no field (display only)
- `up` in 1: single-cycle debounced pulse; increments the selected field.
- `down` in 1: single-cycle debounced pulse; decrements the selected field.
- `alarm_off` in 1: single-cycle pulse; silences the alarm.
- `clk_hour` out 5: 0–23.
- `clk_min` out 6: 0–59.
- `clk_sec` out 6: 0–59.
- `alm_hour` out 5: 0–23.
- `alm_min` out 6: 0–59.
- `alarm_armed` out 1: alarm enabled.
- `alarm_ring` out 1: alarm sounding.
- `sec_tick` out 1: one-cycle pulse on each second boundary.

## Operation
- **Divider.** Counter `cnt` counts 0..TICK_DIV-1 and wraps to 0. It always runs, in every state. On the edge where `cnt==TICK_DIV-1` it generates a tick.
- **States.** Three states: RUN (reset state), RING and ADJ.
  - RUN → ADJ when `adjust=1`.
  - RUN → RING on an alarm match.
  - RING → RUN on `alarm_off`, or when a tick changes `clk_min`.
  - RING → ADJ when `adjust=1`.
  - ADJ → RUN when `adjust=0`.
  - `adjust` has priority over every other transition.
- **Time advance in RUN/RING.** On each tick, `clk_sec` increments.
  - 59 → 0 carries into `clk_min`.
  - `clk_min` 59 → 0 carries into `clk_hour`.
  - `clk_hour` 23 → 0; there is no day carry.
- **Time in ADJ.** Time is frozen and ticks do not advance it.
- **Edits.** Edits apply only in ADJ, and only when `en[3:0]` is exactly one-hot.
  - `up` increments the field: max → 0.
  - `down` decrements the field: 0 → max.
  - Field max is 23 for hours and 59 for minutes. Edits never carry into neighbouring fields.
  - `up` and `down` in the same cycle: ignored.
  - `en` with zero or multiple bits set in [3:0], or only `en[4]`: ignored.
- **Side effects of edits.**
  - Any applied clock-field edit clears `clk_sec` to 0.
  - Any applied alarm-field edit sets `alarm_armed=1`.
  - Reset is the only thing that clears `alarm_armed`.
- **Alarm match.** A tick in RUN whose result is `clk_sec==0`, `clk_hour:clk_min == alm_hour:alm_min`, with `alarm_armed=1`, enters RING at that same edge.
  - An `alarm_off` in the same cycle as the match suppresses it (clear wins).
- **alarm_ring.** Equals 1 exactly while in RING.
- **Entering ADJ from RING.** Drops `alarm_ring` immediately. Leaving ADJ never re-enters RING.

## Timing
- **Reset.** While `rst=0`, asynchronously:
  - all time and alarm fields are 0 and `cnt=0`;
  - `alarm_armed=0`, `alarm_ring=0`, `sec_tick=0`;
  - state is RUN.
- **All outputs are registered.** There is no combinational input→output path.
- **First tick.** It occurs on the TICK_DIV-th rising edge after `rst` deasserts. The new time and `sec_tick=1` are visible in the following cycle, and `sec_tick` lasts exactly one cycle.
- **Edit latency.** An `up`/`down` sampled at edge n shows its result after edge n, i.e. one cycle.
- **State change latency.** `adjust` sampled at edge n changes state at edge n. A tick at that same edge is ignored for time when `adjust=1`.
- **Edit/tick collisions.** A tick and an edit in the same cycle cannot collide, because edits occur only in ADJ and time is frozen there.
- **Reset mid-operation.** Asserting `rst` mid-edit or mid-ring zeros everything immediately, with no waiting for a clock edge.

## Test plan
All scenarios use TICK_DIV=4.
1. **Reset.** Hold `rst=0` for 3 cycles → all outputs 0. Release; after 4 edges `clk_sec=1` and `sec_tick` pulses once. After 40 edges `clk_sec=10`.
2. **Rollover.** `adjust=1`; with `en=00010`, pulse `down` → `clk_hour=23`. With `en=00001`, pulse `down` → `clk_min=59`, `clk_sec=0`. Set `adjust=0`; after 60 ticks → 00:00:00.
3. **Edit rules.** In ADJ:
   - hours `up` at 23 → 0;
   - minutes `down` at 0 → 59;
   - `up`+`down` together → no change;
   - `en=00011` + `up` → no change;
   - `en=10000` + `up` → no change;
   - `adjust=0` + `up` → no change.
4. **Alarm.** From reset, `adjust=1`, `en=00100`, `up` → `alm_min=1`, `alarm_armed=1`. Set `adjust=0`, clock at 00:00:00. After 60 ticks `alarm_ring=1`. Pulse `alarm_off` → `alarm_ring=0` the next cycle.
5. **Ring end.**
   - Repeat scenario 4 with no `alarm_off` → `alarm_ring` falls at the tick making 00:02:00.
   - Pulse `alarm_off` in the cycle of the match → `alarm_ring` never rises.
   - Raise `adjust` while ringing → `alarm_ring=0` next cycle.
6. **Async reset.** Mid-ADJ with `alarm_armed=1`, pull `rst` low between edges → all outputs 0 and `alarm_armed=0` before the next edge.
